// File: rtl/databus_arbiter.sv
// Round-robin arbiter for a 4-source databus mux. A grant is held for a burst of beats
// until the source's last beat, the MAX_BEATS limit, or the source dropping its request.
module databus_arbiter #(
    parameter int unsigned MAX_BEATS = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    input  logic [3:0] last,
    input  logic       bus_ready,
    output logic [1:0] select_source,
    output logic [3:0] grant,
    output logic       bus_valid,
    output logic       xfer_done,
    output logic       xfer_abort,
    output logic [1:0] done_id
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_BUSY  = 1'b1;
    localparam logic [3:0] LAST_CNT = 4'(MAX_BEATS - 1);

    logic [0:0] r_state;
    logic [1:0] r_ptr;
    logic [3:0] r_beat_cnt;
    logic [1:0] r_sel;
    logic [3:0] r_grant;
    logic       r_bus_valid;
    logic       r_xfer_done;
    logic       r_xfer_abort;
    logic [1:0] r_done_id;

    logic       w_pick_valid;
    logic [1:0] w_pick_idx;
    logic       w_accept;
    logic       w_release_done;
    logic       w_release_abort;

    // Descending scan so the candidate closest to the pointer is written last and wins.
    always_comb begin
        logic [1:0] v_cand;
        v_cand       = r_ptr;
        w_pick_valid = 1'b0;
        w_pick_idx   = r_ptr;
        for (int i = 3; i >= 0; i--) begin
            v_cand = r_ptr + 2'(i);
            if (req[v_cand]) begin
                w_pick_valid = 1'b1;
                w_pick_idx   = v_cand;
            end
        end
    end

    assign w_accept        = (r_state == ST_BUSY) && bus_ready;
    // An accepted beat always wins over a dropped request, so abort needs no accept.
    assign w_release_done  = w_accept &&
                             (last[r_sel] || (r_beat_cnt == LAST_CNT) || !req[r_sel]);
    assign w_release_abort = (r_state == ST_BUSY) && !w_accept && !req[r_sel];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_ptr        <= 2'd0;
            r_beat_cnt   <= 4'd0;
            r_sel        <= 2'd0;
            r_grant      <= 4'd0;
            r_bus_valid  <= 1'b0;
            r_xfer_done  <= 1'b0;
            r_xfer_abort <= 1'b0;
            r_done_id    <= 2'd0;
        end else begin
            r_xfer_done  <= 1'b0;
            r_xfer_abort <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_pick_valid) begin
                        r_state     <= ST_BUSY;
                        r_sel       <= w_pick_idx;
                        r_grant     <= 4'b0001 << w_pick_idx;
                        r_bus_valid <= 1'b1;
                        r_beat_cnt  <= 4'd0;
                    end
                end
                ST_BUSY: begin
                    if (w_release_done || w_release_abort) begin
                        r_state      <= ST_IDLE;
                        r_grant      <= 4'd0;
                        r_bus_valid  <= 1'b0;
                        r_beat_cnt   <= 4'd0;
                        r_ptr        <= r_sel + 2'd1;
                        r_xfer_done  <= w_release_done;
                        r_xfer_abort <= w_release_abort;
                        r_done_id    <= r_sel;
                    end else if (w_accept) begin
                        r_beat_cnt <= r_beat_cnt + 4'd1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign select_source = r_sel;
    assign grant         = r_grant;
    assign bus_valid     = r_bus_valid;
    assign xfer_done     = r_xfer_done;
    assign xfer_abort    = r_xfer_abort;
    assign done_id       = r_done_id;

endmodule
